// File: rtl/phy_init_seq.sv
// phy_init_seq
//   Board-level bring-up sequencer. After PLL lock it holds the PHY in hardware
//   reset, waits for the PHY to settle, writes NUM_CMDS registers over MDIO and
//   then releases the system reset. It also hands the MDIO pins to the MAC.
//
// Ports:
//   clk, reset_n        - system clock, synchronous active-low reset
//   pll_locked          - asynchronous PLL lock (double-flopped here)
//   phy_reset_n         - PHY hardware reset, active low
//   sys_reset_n         - Nios/MAC system reset, active low
//   init_done           - configuration complete, MAC owns MDIO
//   init_error          - PHY ID mismatch (PHY_ID_CHECK_EN only, else 0)
//   mdc/mdio_out/mdio_oen - MDIO pin drive (oen=1 releases the pin)
//   mdio_in             - MDIO pin value (double-flopped when used)
//   mac_mdc/mac_mdio_out/mac_mdio_oen - MAC MDIO conduit, passed through in DONE
//
// Optional feature macro: PHY_ID_CHECK_EN (reads PHY ID1 and compares it
// against EXPECTED_ID before releasing the system).
module phy_init_seq #(
  parameter int unsigned CLK_DIV      = 25,
  parameter int unsigned RESET_CYCLES = 500000,
  parameter int unsigned WAIT_CYCLES  = 250000,
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned NUM_CMDS     = 2,
  parameter logic [20:0] CMD0         = 21'h0,
  parameter logic [20:0] CMD1         = 21'h0,
  parameter logic [20:0] CMD2         = 21'h0,
  parameter logic [20:0] CMD3         = 21'h0,
  parameter logic [15:0] EXPECTED_ID  = 16'h0141
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  output logic phy_reset_n,
  output logic sys_reset_n,
  output logic init_done,
  output logic init_error,
  output logic mdc,
  output logic mdio_out,
  output logic mdio_oen,
  input  logic mdio_in,
  input  logic mac_mdc,
  input  logic mac_mdio_out,
  input  logic mac_mdio_oen
);

  localparam int unsigned MAX_CYC = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned DW      = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, RST_HOLD, RST_WAIT, FRAME, GAP,
`ifdef PHY_ID_CHECK_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            lock_s1_q, lock_s2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic [1:0]      cmd_idx_q, cmd_idx_d;
  logic [63:0]     sh_q, sh_d;
  logic            phy_rst_q, phy_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            done_q, done_d;
  logic            mdc_q, mdc_d;
  logic            oen_q, oen_d;

`ifdef PHY_ID_CHECK_EN
  logic            mdio_s1_q, mdio_s2_q;
  logic            err_q, err_d;
  logic            chk_q, chk_d;
  logic [15:0]     rd_q, rd_d;
`else
  logic            unused_cfg;
  assign unused_cfg = ^{mdio_in, EXPECTED_ID};
`endif

  function automatic logic [63:0] wr_frame(input logic [1:0] idx);
    logic [20:0] c;
    case (idx)
      2'd0:    c = CMD0;
      2'd1:    c = CMD1;
      2'd2:    c = CMD2;
      default: c = CMD3;
    endcase
    return {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, c[20:16], 2'b10, c[15:0]};
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    div_d     = div_q;
    bit_d     = bit_q;
    cmd_idx_d = cmd_idx_q;
    sh_d      = sh_q;
    phy_rst_d = phy_rst_q;
    sys_rst_d = sys_rst_q;
    done_d    = done_q;
    mdc_d     = mdc_q;
    oen_d     = oen_q;
`ifdef PHY_ID_CHECK_EN
    err_d     = err_q;
    chk_d     = chk_q;
    rd_d      = rd_q;
`endif
    if (!lock_s2_q) begin
      // Lock lost (or not yet present): abandon everything, park at IDLE.
      state_d   = IDLE;
      div_d     = '0;
      bit_d     = '0;
      cmd_idx_d = '0;
      sh_d      = '1;
      phy_rst_d = 1'b0;
      sys_rst_d = 1'b0;
      done_d    = 1'b0;
      mdc_d     = 1'b0;
      oen_d     = 1'b1;
`ifdef PHY_ID_CHECK_EN
      err_d     = 1'b0;
      chk_d     = 1'b0;
      rd_d      = '0;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = RST_HOLD;
        RST_HOLD: begin
          if (cnt_q == CW'(RESET_CYCLES - 1)) begin
            phy_rst_d = 1'b1;
            state_d   = RST_WAIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RST_WAIT: begin
          if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
            state_d   = FRAME;
            cmd_idx_d = '0;
            div_d     = '0;
            bit_d     = '0;
            sh_d      = wr_frame(2'd0);
            oen_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // Write and read frames share the bit timer; the read frame only adds
        // the pin release at TA and sampling of the data bits.
`ifdef PHY_ID_CHECK_EN
        FRAME, CHECK: begin
`else
        FRAME: begin
`endif
          div_d = div_q + DW'(1);
          if (div_q == DW'(CLK_DIV - 1)) begin
            mdc_d = 1'b1;
`ifdef PHY_ID_CHECK_EN
            if (state_q == CHECK && bit_q >= 6'd48)
              rd_d = {rd_q[14:0], mdio_s2_q};
`endif
          end
          if (div_q == DW'(2 * CLK_DIV - 1)) begin
            div_d = '0;
            mdc_d = 1'b0;
            sh_d  = {sh_q[62:0], 1'b1};
            if (bit_q == 6'd63) begin
              state_d = GAP;
              oen_d   = 1'b1;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 6'd1;
`ifdef PHY_ID_CHECK_EN
              if (state_q == CHECK && bit_q == 6'd45)
                oen_d = 1'b1;
`endif
            end
          end
        end
        GAP: begin
          div_d = div_q + DW'(1);
          if (div_q == DW'(2 * CLK_DIV - 1)) begin
            div_d = '0;
`ifdef PHY_ID_CHECK_EN
            if (chk_q) begin
              state_d   = DONE;
              done_d    = 1'b1;
              sys_rst_d = 1'b1;
              err_d     = (rd_q != EXPECTED_ID);
            end else
`endif
            if ({30'd0, cmd_idx_q} + 32'd1 < NUM_CMDS) begin
              cmd_idx_d = cmd_idx_q + 2'd1;
              state_d   = FRAME;
              sh_d      = wr_frame(cmd_idx_q + 2'd1);
              oen_d     = 1'b0;
            end else begin
`ifdef PHY_ID_CHECK_EN
              state_d = CHECK;
              chk_d   = 1'b1;
              sh_d    = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd2, 18'h3FFFF};
              oen_d   = 1'b0;
`else
              state_d   = DONE;
              done_d    = 1'b1;
              sys_rst_d = 1'b1;
`endif
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      cmd_idx_q <= '0;
      sh_q      <= '1;
      phy_rst_q <= 1'b0;
      sys_rst_q <= 1'b0;
      done_q    <= 1'b0;
      mdc_q     <= 1'b0;
      oen_q     <= 1'b1;
`ifdef PHY_ID_CHECK_EN
      mdio_s1_q <= 1'b1;
      mdio_s2_q <= 1'b1;
      err_q     <= 1'b0;
      chk_q     <= 1'b0;
      rd_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      lock_s1_q <= pll_locked;
      lock_s2_q <= lock_s1_q;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      cmd_idx_q <= cmd_idx_d;
      sh_q      <= sh_d;
      phy_rst_q <= phy_rst_d;
      sys_rst_q <= sys_rst_d;
      done_q    <= done_d;
      mdc_q     <= mdc_d;
      oen_q     <= oen_d;
`ifdef PHY_ID_CHECK_EN
      mdio_s1_q <= mdio_in;
      mdio_s2_q <= mdio_s1_q;
      err_q     <= err_d;
      chk_q     <= chk_d;
      rd_q      <= rd_d;
`endif
    end
  end

  assign phy_reset_n = phy_rst_q;
  assign sys_reset_n = sys_rst_q;
  assign init_done   = done_q;
  assign mdc         = done_q ? mac_mdc      : mdc_q;
  assign mdio_out    = done_q ? mac_mdio_out : sh_q[63];
  assign mdio_oen    = done_q ? mac_mdio_oen : oen_q;
`ifdef PHY_ID_CHECK_EN
  assign init_error  = err_q;
`else
  assign init_error  = 1'b0;
`endif

endmodule

// File: tb/tb_phy_init_seq.sv
// Directed bench for phy_init_seq with small timing parameters.
module tb_phy_init_seq;

  localparam logic [63:0] F0 = {32'hFFFF_FFFF, 32'b01_01_00001_10100_10_0000110011100000};
  localparam logic [63:0] F1 = {32'hFFFF_FFFF, 32'b01_01_00001_00000_10_1000000101000000};
  localparam logic [45:0] RD_HDR = {32'hFFFF_FFFF, 14'b01_10_00001_00010};
`ifdef PHY_ID_CHECK_EN
  localparam int unsigned NFR = 3;
  localparam int unsigned EXP_TOTAL = 2 + 100 + 50 + 3 * 65 * 8;
`else
  localparam int unsigned NFR = 2;
  localparam int unsigned EXP_TOTAL = 2 + 100 + 50 + 2 * 65 * 8;
`endif

  logic clk = 1'b0;
  logic reset_n, pll_locked;
  logic phy_reset_n, sys_reset_n, init_done, init_error;
  logic mdc, mdio_out, mdio_oen;
  logic mdio_in = 1'b1;
  logic mac_mdc, mac_mdio_out, mac_mdio_oen;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  // MDIO monitor / PHY model state
  logic        mdc_prev = 1'b0;
  logic        is_read = 1'b0;
  logic [63:0] shreg = '0;
  logic [63:0] frames [8];
  int unsigned rise_cnt = 0;
  int unsigned frame_cnt = 0;
  logic [15:0] phy_id = 16'h0141;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  phy_init_seq #(
    .CLK_DIV(4), .RESET_CYCLES(100), .WAIT_CYCLES(50), .PHY_ADDR(5'd1), .NUM_CMDS(2),
    .CMD0({5'd20, 16'h0CE0}), .CMD1({5'd0, 16'h8140}), .EXPECTED_ID(16'h0141)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .phy_reset_n(phy_reset_n), .sys_reset_n(sys_reset_n),
    .init_done(init_done), .init_error(init_error),
    .mdc(mdc), .mdio_out(mdio_out), .mdio_oen(mdio_oen), .mdio_in(mdio_in),
    .mac_mdc(mac_mdc), .mac_mdio_out(mac_mdio_out), .mac_mdio_oen(mac_mdio_oen)
  );

  // Captures mdio_out on every mdc rise; answers read frames with phy_id,
  // changing mdio_in just after a rise so it is stable for the next one.
  always @(negedge clk) begin
    if (!phy_reset_n) begin
      rise_cnt = 0; frame_cnt = 0; is_read = 1'b0; mdio_in = 1'b1;
      foreach (frames[i]) frames[i] = '0;
    end else if (!init_done && mdc && !mdc_prev) begin
      shreg = {shreg[62:0], mdio_out};
      rise_cnt++;
      if (rise_cnt == 36) is_read = (shreg[1:0] == 2'b10);
      if (is_read && rise_cnt >= 48 && rise_cnt <= 63) mdio_in = phy_id[63 - rise_cnt];
      else mdio_in = 1'b1;
      if (rise_cnt == 64) begin
        frames[frame_cnt % 8] = shreg;
        frame_cnt++;
        rise_cnt = 0;
        is_read = 1'b0;
      end
    end
    mdc_prev = mdc;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int unsigned sel);
    case (sel)
      0: return phy_reset_n;
      1: return mdc;
      2: return frame_cnt >= 1;
      3: return !mdc;
      4: return init_done;
      5: return frame_cnt >= 1 && rise_cnt >= 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int unsigned sel, input int unsigned limit,
                          output int unsigned n);
    n = 0;
    while (!cond(sel) && n < limit) begin
      tick(1);
      n++;
    end
    check({tag, "_in_time"}, 64'(n < limit), 64'd1);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_phy_reset_n"}, 64'(phy_reset_n), 64'd0);
    check({p, "_sys_reset_n"}, 64'(sys_reset_n), 64'd0);
    check({p, "_init_done"},   64'(init_done),   64'd0);
    check({p, "_init_error"},  64'(init_error),  64'd0);
    check({p, "_mdc"},         64'(mdc),         64'd0);
    check({p, "_mdio_out"},    64'(mdio_out),    64'd1);
    check({p, "_mdio_oen"},    64'(mdio_oen),    64'd1);
  endtask

  task automatic check_done(input string p, input logic exp_err);
    check({p, "_init_done"},  64'(init_done),   64'd1);
    check({p, "_sys_reset_n"},64'(sys_reset_n), 64'd1);
    check({p, "_init_error"}, 64'(init_error),  64'(exp_err));
    check({p, "_frame_cnt"},  64'(frame_cnt),   64'(NFR));
    check({p, "_frame0"},     frames[0],        F0);
    check({p, "_frame1"},     frames[1],        F1);
    check({p, "_f1_reg"},     64'(frames[1][22:18]), 64'd0);
    check({p, "_f1_data"},    64'(frames[1][15:0]),  64'h8140);
`ifdef PHY_ID_CHECK_EN
    check({p, "_read_hdr"},   64'(frames[2][63:18]), 64'(RD_HDR));
`endif
  endtask

  initial begin
    int unsigned n;
    int unsigned t_lock;
    reset_n = 1'b0; pll_locked = 1'b0;
    mac_mdc = 1'b0; mac_mdio_out = 1'b1; mac_mdio_oen = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check_reset_vals("rst");

    // Run 1: lock at ~cycle 10, full sequence
    tick(5);
    pll_locked = 1'b1;
    t_lock = cyc;
    wait_for("phy_rel", 0, 300, n);
    check("phy_rel_lat_100pm2", 64'(n >= 100 && n <= 104), 64'd1);
    wait_for("mdc_rise", 1, 200, n);
    check("mdc_lat_54pm2", 64'(n >= 52 && n <= 56), 64'd1);
    check("sys_low_in_frame", 64'(sys_reset_n), 64'd0);
    check("oen_in_frame", 64'(mdio_oen), 64'd0);
    wait_for("frame0", 2, 1000, n);
    wait_for("gap_start", 3, 20, n);
    tick(1);
    check("gap_oen", 64'(mdio_oen), 64'd1);
    check("gap_mdc", 64'(mdc), 64'd0);
    check("gap_sys_low", 64'(sys_reset_n), 64'd0);
    wait_for("done1", 4, 3000, n);
    check("total_lat", 64'((cyc - t_lock) >= EXP_TOTAL - 2 && (cyc - t_lock) <= EXP_TOTAL + 2), 64'd1);
    check_done("run1", 1'b0);

    // MAC pass-through, same cycle
    mac_mdc = 1'b1; mac_mdio_out = 1'b0; mac_mdio_oen = 1'b0;
    #1;
    check("pt1_mdc", 64'(mdc), 64'd1);
    check("pt1_mdio_out", 64'(mdio_out), 64'd0);
    check("pt1_mdio_oen", 64'(mdio_oen), 64'd0);
    mac_mdc = 1'b0; mac_mdio_out = 1'b1; mac_mdio_oen = 1'b0;
    #1;
    check("pt2_mdc", 64'(mdc), 64'd0);
    check("pt2_mdio_out", 64'(mdio_out), 64'd1);
    check("pt2_mdio_oen", 64'(mdio_oen), 64'd0);
    mac_mdc = 1'b0; mac_mdio_out = 1'b1; mac_mdio_oen = 1'b1;
    tick(1);

    // Lock loss from DONE, then relock and drop lock mid-frame 1
    pll_locked = 1'b0;
    tick(4);
    check("unlock_done_low", 64'(init_done), 64'd0);
    check("unlock_sys_low", 64'(sys_reset_n), 64'd0);
    pll_locked = 1'b1;
    wait_for("mid_f1", 5, 3000, n);
    pll_locked = 1'b0;
    tick(3);
    check("midloss_phy_reset_n", 64'(phy_reset_n), 64'd0);
    check("midloss_mdio_oen", 64'(mdio_oen), 64'd1);
    check("midloss_mdc", 64'(mdc), 64'd0);
    check("midloss_sys_reset_n", 64'(sys_reset_n), 64'd0);
    pll_locked = 1'b1;
    wait_for("done2", 4, 3000, n);
    check_done("relock", 1'b0);

    // reset_n pulse during RST_WAIT with lock held
    pll_locked = 1'b0;
    tick(4);
    pll_locked = 1'b1;
    wait_for("phy_rel3", 0, 300, n);
    tick(10);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_reset_vals("rstpulse");
    wait_for("done3", 4, 3000, n);
    check_done("after_rst", 1'b0);

`ifdef PHY_ID_CHECK_EN
    phy_id = 16'h0022;
    pll_locked = 1'b0;
    tick(4);
    check("badid_err_cleared", 64'(init_error), 64'd0);
    pll_locked = 1'b1;
    wait_for("done4", 4, 3000, n);
    check_done("bad_id", 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
